// File: rtl/vco_pkg.sv
// Shared widths, FSM state encoding and default gate length for the VCO frequency detector.
package vco_pkg;
  localparam int PHASE_W       = 25;
  localparam int CODE_W        = 8;
  localparam int GATE_LOG2_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    CALC    = 2'd3
  } state_t;
endpackage

// File: rtl/vco_code_sat.sv
// Stateless mapping of mean phase increment to code: subtract offset, arithmetic shift, clamp to 0..255.
module vco_code_sat
  import vco_pkg::*;
#(
  parameter int OFFSET = 0,
  parameter int SHIFT  = 0
) (
  input  logic [PHASE_W-1:0] avg,
  output logic [CODE_W-1:0]  code
);

  // Wide enough for a 25-bit avg minus any 32-bit OFFSET without wrapping.
  localparam int W = 34;
  localparam logic signed [W-1:0] OFF_S = W'(OFFSET);
  localparam logic signed [W-1:0] MAX_S = W'((1 << CODE_W) - 1);

  logic signed [W-1:0] diff;
  logic signed [W-1:0] val;

  always_comb begin
    diff = $signed({{(W-PHASE_W){1'b0}}, avg}) - OFF_S;
    val  = diff >>> SHIFT;
    code = '0;
    if (val[W-1]) begin
      code = '0;
    end else if (val > MAX_S) begin
      code = '1;
    end else begin
      code = val[CODE_W-1:0];
    end
  end

endmodule

// File: rtl/vco_freq_detector.sv
// Averages VCO phase increments over 2**GATE_LOG2 cycles; result valid start+2**GATE_LOG2+2 edges later.
// Single-entry output: an unconsumed result is overwritten and flagged by sticky overrun.
module vco_freq_detector
  import vco_pkg::*;
#(
  parameter int GATE_LOG2 = GATE_LOG2_DEF,
  parameter int OFFSET    = 0,
  parameter int SHIFT     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               start,
  input  logic               code_ready,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int ACC_W = PHASE_W + GATE_LOG2;
  localparam logic [GATE_LOG2:0] CNT_LAST = (GATE_LOG2+1)'((1 << GATE_LOG2) - 1);
  localparam logic [GATE_LOG2:0] CNT_ONE  = (GATE_LOG2+1)'(1);

  state_t               state;
  logic [PHASE_W-1:0]   phase_prev;
  logic [PHASE_W-1:0]   diff;
  logic [PHASE_W-1:0]   avg;
  logic [ACC_W-1:0]     acc;
  logic [GATE_LOG2:0]   cnt;
  logic [CODE_W-1:0]    code_nxt;

  // Modular subtraction absorbs any phase wrap between consecutive samples.
  assign diff = phase_in - phase_prev;
  assign avg  = acc[ACC_W-1:GATE_LOG2];
  assign busy = (state != IDLE);

  vco_code_sat #(
    .OFFSET (OFFSET),
    .SHIFT  (SHIFT)
  ) u_sat (
    .avg  (avg),
    .code (code_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      phase_prev <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= ARM;
        end
        ARM: begin
          phase_prev <= phase_in;
          acc        <= '0;
          cnt        <= '0;
          state      <= MEASURE;
        end
        MEASURE: begin
          acc        <= acc + ACC_W'(diff);
          phase_prev <= phase_in;
          cnt        <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) state <= CALC;
        end
        CALC: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new result always wins; overrun only when the old one was never taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code       <= '0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (state == CALC) begin
      code       <= code_nxt;
      code_valid <= 1'b1;
      if (code_valid && !code_ready) overrun <= 1'b1;
    end else if (code_valid && code_ready) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vco_freq_detector.sv
// Bench for vco_freq_detector: two instances (plain, and OFFSET=200/SHIFT=1) share stimulus.
module tb_vco_freq_detector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] phase_in = '0;
  logic        start = 1'b0;
  logic        code_ready = 1'b0;

  logic [7:0]  code_a, code_b;
  logic        code_valid_a, code_valid_b;
  logic        busy_a, busy_b;
  logic        overrun_a, overrun_b;

  vco_freq_detector #(.GATE_LOG2(4), .OFFSET(0), .SHIFT(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .phase_in   (phase_in),
    .start      (start),
    .code_ready (code_ready),
    .code       (code_a),
    .code_valid (code_valid_a),
    .busy       (busy_a),
    .overrun    (overrun_a)
  );

  vco_freq_detector #(.GATE_LOG2(4), .OFFSET(200), .SHIFT(1)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .phase_in   (phase_in),
    .start      (start),
    .code_ready (code_ready),
    .code       (code_b),
    .code_valid (code_valid_b),
    .busy       (busy_b),
    .overrun    (overrun_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  typedef struct {
    longint st_ph;
    int     inc;
    int     exp_a;
    int     exp_b;
  } vec_t;

  int      n_vec = 0;
  int      n_err = 0;
  longint  true_ph = 0;
  int      inc_now = 0;
  bit      rnd = 1'b0;
  bit      rnd_big = 1'b0;
  int      edge_n = 0;
  int      t0 = 0;
  longint  hist [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock: record the phase the DUT saw at this edge, then advance phase.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    hist[edge_n] = true_ph;
    #1;
    if (rnd) begin
      if (rnd_big) inc_now = int'($urandom_range(0, (1 << 24) - 1));
      else         inc_now = int'($urandom_range(0, 700));
    end
    true_ph = true_ph + longint'(inc_now);
    phase_in = true_ph[24:0];
  endtask

  // Reference: mean increment is the true phase advance over the window / 16.
  function automatic int model(input longint sum, input int off, input int sh);
    longint v;
    v = (sum / 16) - longint'(off);
    if (v < 0) return 0;
    v = v / (longint'(1) << sh);
    return (v > 255) ? 255 : int'(v);
  endfunction

  task automatic begin_meas(input longint st_ph, input int inc, input bit rnd_i);
    true_ph  = st_ph;
    phase_in = true_ph[24:0];
    inc_now  = inc;
    rnd      = rnd_i;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    t0       = edge_n;
    check("busy_after_start", busy_a, 1'b1);
  endtask

  task automatic finish_meas(input bit chk_lat, input bit use_model, input bit cr_calc,
                             input int ea, input int eb);
    int xa, xb;
    longint sum;
    while (edge_n < t0 + 17) tick();
    if (chk_lat) begin
      check("valid_early_a", code_valid_a, 1'b0);
      check("valid_early_b", code_valid_b, 1'b0);
    end
    check("busy_in_window", busy_a, 1'b1);
    code_ready = cr_calc;
    tick();
    sum = hist[t0 + 17] - hist[t0 + 1];
    xa = use_model ? model(sum, 0, 0)   : ea;
    xb = use_model ? model(sum, 200, 1) : eb;
    check("valid_at_latency_a", code_valid_a, 1'b1);
    check("valid_at_latency_b", code_valid_b, 1'b1);
    check("code_a", code_a, xa);
    check("code_b", code_b, xb);
    check("busy_after_calc", busy_a, 1'b0);
  endtask

  task automatic consume();
    code_ready = 1'b1;
    tick();
    code_ready = 1'b0;
    check("valid_cleared_a", code_valid_a, 1'b0);
    check("valid_cleared_b", code_valid_b, 1'b0);
  endtask

  vec_t vecs [13];

  initial begin
    int stray_v, stray_b;

    vecs[0]  = '{0,                  128,      128, 0};
    vecs[1]  = '{0,                  300,      255, 50};
    vecs[2]  = '{0,                  100,      100, 0};
    vecs[3]  = '{33554432 - 200,     128,      128, 0};
    vecs[4]  = '{12345,              0,        0,   0};
    vecs[5]  = '{0,                  455,      255, 127};
    vecs[6]  = '{0,                  711,      255, 255};
    vecs[7]  = '{0,                  713,      255, 255};
    vecs[8]  = '{0,                  201,      201, 0};
    vecs[9]  = '{0,                  202,      202, 1};
    vecs[10] = '{0,                  255,      255, 27};
    vecs[11] = '{0,                  256,      255, 28};
    vecs[12] = '{33554432 - 1000,    16777215, 255, 255};

    // Asynchronous reset, no clock edge needed.
    #1 rst = 1'b0;
    #1;
    check("rst_code_a",    code_a,       8'd0);
    check("rst_valid_a",   code_valid_a, 1'b0);
    check("rst_busy_a",    busy_a,       1'b0);
    check("rst_overrun_a", overrun_a,    1'b0);
    check("rst_code_b",    code_b,       8'd0);
    check("rst_valid_b",   code_valid_b, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("idle_after_rst", busy_a, 1'b0);

    foreach (vecs[i]) begin
      code_ready = 1'b0;
      begin_meas(vecs[i].st_ph, vecs[i].inc, 1'b0);
      finish_meas(1'b1, 1'b0, 1'b0, vecs[i].exp_a, vecs[i].exp_b);
      consume();
    end
    check("no_overrun_after_table", overrun_a, 1'b0);

    // CALC completes on the same edge the old result is accepted.
    code_ready = 1'b0;
    begin_meas(0, 128, 1'b0);
    finish_meas(1'b1, 1'b0, 1'b0, 128, 0);
    begin_meas(0, 64, 1'b0);
    finish_meas(1'b0, 1'b0, 1'b1, 64, 0);
    code_ready = 1'b0;
    check("same_cycle_accept_overrun_a", overrun_a, 1'b0);
    check("same_cycle_accept_overrun_b", overrun_b, 1'b0);
    consume();

    // Start pulses during MEASURE must be ignored.
    begin_meas(0, 128, 1'b0);
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    finish_meas(1'b1, 1'b0, 1'b0, 128, 0);
    code_ready = 1'b1;
    stray_v = 0;
    stray_b = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (code_valid_a) stray_v++;
      if (busy_a) stray_b++;
    end
    check("ignored_start_valid_cycles", stray_v, 0);
    check("ignored_start_busy_cycles",  stray_b, 0);
    code_ready = 1'b0;

    // Two results without consumption: overwrite and sticky overrun.
    begin_meas(0, 128, 1'b0);
    finish_meas(1'b1, 1'b0, 1'b0, 128, 0);
    begin_meas(0, 64, 1'b0);
    finish_meas(1'b0, 1'b0, 1'b0, 64, 0);
    check("overrun_set_a", overrun_a, 1'b1);
    check("overrun_set_b", overrun_b, 1'b1);
    consume();
    check("overrun_sticky_a", overrun_a, 1'b1);
    check("overrun_sticky_b", overrun_b, 1'b1);

    // Reset five cycles into MEASURE discards the measurement.
    begin_meas(0, 128, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_code_a",    code_a,       8'd0);
    check("midrst_valid_a",   code_valid_a, 1'b0);
    check("midrst_busy_a",    busy_a,       1'b0);
    check("midrst_overrun_a", overrun_a,    1'b0);
    check("midrst_overrun_b", overrun_b,    1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    stray_v = 0;
    stray_b = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (code_valid_a || code_valid_b) stray_v++;
      if (busy_a) stray_b++;
    end
    check("midrst_stale_valid_cycles", stray_v, 0);
    check("midrst_stale_busy_cycles",  stray_b, 0);
    begin_meas(0, 128, 1'b0);
    finish_meas(1'b1, 1'b0, 1'b0, 128, 0);
    consume();

    // Randomized per-cycle increments against the reference model.
    for (int r = 0; r < 30; r++) begin
      rnd_big = ($urandom_range(0, 3) == 0);
      begin_meas(longint'($urandom_range(0, (1 << 25) - 1)), int'($urandom_range(0, 700)), 1'b1);
      finish_meas(1'b1, 1'b1, 1'b0, 0, 0);
      consume();
    end
    rnd = 1'b0;
    check("final_overrun_a", overrun_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
